// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode-control stage: opcodes, ALU codes,
// result/immediate selectors and the per-entry control record.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } res_src_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src_a;
        logic        alu_src_b;
        res_src_e    result_src;
        imm_src_e    imm_src;
        alu_op_e     alu_ctrl;
        logic [2:0]  br_funct3;
        logic        illegal;
    } ctrl_t;

    // Only R-type may turn funct3=000 into SUB; shifts honour funct7[5] for both forms.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       funct7_b5,
                                                input logic       is_rtype);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_ctrl_pipe_if.sv
// Decode-to-Execute handshake bundle; slave is the pipe stage, master the driver/observer.
interface decode_ctrl_pipe_if #(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr_d;
    logic [XLEN-1:0]       pc_d;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           instr_e;
    logic [XLEN-1:0]       pc_e;
    logic                  reg_write_e;
    logic                  mem_write_e;
    logic                  branch_e;
    logic                  jump_e;
    logic                  jalr_e;
    logic                  alu_src_a_e;
    logic                  alu_src_b_e;
    logic [1:0]            result_src_e;
    logic [2:0]            imm_src_e;
    logic [ALU_CTRL_W-1:0] alu_ctrl_e;
    logic [2:0]            br_funct3_e;
    logic                  illegal_e;
    logic [CNT_W-1:0]      illegal_cnt;

    modport slave (
        input  flush, in_valid, instr_d, pc_d, out_ready,
        output in_ready, out_valid, instr_e, pc_e,
               reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
               alu_src_a_e, alu_src_b_e, result_src_e, imm_src_e,
               alu_ctrl_e, br_funct3_e, illegal_e, illegal_cnt
    );

    modport master (
        output flush, in_valid, instr_d, pc_d, out_ready,
        input  in_ready, out_valid, instr_e, pc_e,
               reg_write_e, mem_write_e, branch_e, jump_e, jalr_e,
               alu_src_a_e, alu_src_b_e, result_src_e, imm_src_e,
               alu_ctrl_e, br_funct3_e, illegal_e, illegal_cnt
    );
endinterface

// File: rtl/rv32i_ctrl_dec.sv
// Pure combinational RV32I base-opcode decoder: instruction word to one control record.
module rv32i_ctrl_dec
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7_b5 = instr_i[30];

    always_comb begin
        // NOTE: every field gets a default before the case, so no path can infer a latch.
        ctrl_o       = '0;
        ctrl_o.instr = instr_i;
        case (opcode)
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.result_src = RES_MEM;
                ctrl_o.imm_src    = IMM_I;
                ctrl_o.alu_ctrl   = ALU_ADD;
            end
            OP_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.imm_src   = IMM_S;
                ctrl_o.alu_ctrl  = ALU_ADD;
            end
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_ctrl  = alu_from_funct3(funct3, funct7_b5, 1'b1);
            end
            OP_IALU: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.imm_src   = IMM_I;
                ctrl_o.alu_ctrl  = alu_from_funct3(funct3, funct7_b5, 1'b0);
            end
            OP_BRANCH: begin
                ctrl_o.branch    = 1'b1;
                ctrl_o.imm_src   = IMM_B;
                ctrl_o.br_funct3 = funct3;
                ctrl_o.alu_ctrl  = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
            end
            OP_JAL: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jump       = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.imm_src    = IMM_J;
            end
            OP_JALR: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.jump       = 1'b1;
                ctrl_o.jalr       = 1'b1;
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.imm_src    = IMM_I;
                ctrl_o.alu_ctrl   = ALU_ADD;
            end
            OP_LUI: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_IMM;
                ctrl_o.imm_src    = IMM_U;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.imm_src   = IMM_U;
                ctrl_o.alu_ctrl  = ALU_ADD;
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode-control stage with a 2-entry skid buffer, flush and handshake.
// Optional DECODE_ILLEGAL_TRAP_EN enables illegal_e reporting and the saturating illegal_cnt.
module decode_ctrl_pipe
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst,
    decode_ctrl_pipe_if.slave bus
);
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    ctrl_t           dec_ctrl;
    ctrl_t           wr_ctrl;
    ctrl_t           slot0_q, slot0_d, slot1_q, slot1_d;
    logic [XLEN-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]      count_q, count_d;
    logic            push, pop;

    rv32i_ctrl_dec u_dec (
        .instr_i (bus.instr_d),
        .ctrl_o  (dec_ctrl)
    );

    always_comb begin
        wr_ctrl         = dec_ctrl;
        wr_ctrl.illegal = TRAP_EN && dec_ctrl.illegal;
    end

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_ready && bus.out_valid;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: if (push) begin
                    slot0_d = wr_ctrl;
                    pc0_d   = bus.pc_d;
                    count_d = 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0_d = wr_ctrl;
                        pc0_d   = bus.pc_d;
                    end else if (push) begin
                        slot1_d = wr_ctrl;
                        pc1_d   = bus.pc_d;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: if (pop) begin
                    slot0_d = slot1_q;
                    pc0_d   = pc1_q;
                    count_d = 2'd1;
                end
            endcase
        end
    end

    // NOTE: the buffer slots are reset as well, because every _e output must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            pc0_q   <= '0;
            pc1_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
        end
    end

    assign bus.instr_e      = slot0_q.instr;
    assign bus.pc_e         = pc0_q;
    assign bus.reg_write_e  = slot0_q.reg_write;
    assign bus.mem_write_e  = slot0_q.mem_write;
    assign bus.branch_e     = slot0_q.branch;
    assign bus.jump_e       = slot0_q.jump;
    assign bus.jalr_e       = slot0_q.jalr;
    assign bus.alu_src_a_e  = slot0_q.alu_src_a;
    assign bus.alu_src_b_e  = slot0_q.alu_src_b;
    assign bus.result_src_e = slot0_q.result_src;
    assign bus.imm_src_e    = slot0_q.imm_src;
    assign bus.alu_ctrl_e   = ALU_CTRL_W'(slot0_q.alu_ctrl);
    assign bus.br_funct3_e  = slot0_q.br_funct3;
    assign bus.illegal_e    = slot0_q.illegal;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic [CNT_W-1:0] illegal_cnt_q;

    // A flushed push never lands in the buffer, so it must not be counted either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else if (push && !bus.flush && dec_ctrl.illegal && (illegal_cnt_q != '1)) begin
            illegal_cnt_q <= illegal_cnt_q + 1'b1;
        end
    end

    assign bus.illegal_cnt = illegal_cnt_q;
`else
    assign bus.illegal_cnt = '0;
`endif
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Self-checking bench for decode_ctrl_pipe: directed steps then random traffic against a
// queue-based reference model. Honours DECODE_ILLEGAL_TRAP_EN the same way as the design.
module tb_decode_ctrl_pipe;
`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int XLEN = 32;
    localparam int ALUW = 4;
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_ctrl_pipe_if #(.XLEN(XLEN), .ALU_CTRL_W(ALUW), .CNT_W(CNTW)) bus ();

    decode_ctrl_pipe #(.XLEN(XLEN), .ALU_CTRL_W(ALUW), .CNT_W(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   cnt_m = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    endfunction

    // Expected {rw,mw,br,jump,jalr,aluA,aluB,res[1:0],imm[2:0],alu[3:0]} from the opcode table.
    function automatic logic [15:0] exp_ctrl(input logic [31:0] ins);
        logic [6:0] op;
        int f3, alu, res, imm;
        bit rw, mw, br, jp, jr, aa, ab, f7;
        op = ins[6:0]; f3 = int'(ins[14:12]); f7 = ins[30];
        {rw, mw, br, jp, jr, aa, ab} = '0;
        alu = 0; res = 0; imm = 0;
        case (op)
            7'h03: begin rw = 1; ab = 1; res = 1; imm = 0; end
            7'h23: begin mw = 1; ab = 1; imm = 1; end
            7'h33: rw = 1;
            7'h13: begin rw = 1; ab = 1; imm = 0; end
            7'h63: begin br = 1; imm = 2; end
            7'h6F: begin rw = 1; jp = 1; res = 2; imm = 3; end
            7'h67: begin rw = 1; jp = 1; jr = 1; ab = 1; res = 2; imm = 0; end
            7'h37: begin rw = 1; res = 3; imm = 4; end
            7'h17: begin rw = 1; aa = 1; ab = 1; imm = 4; end
            default: ;
        endcase
        if (op == 7'h33 || op == 7'h13) begin
            int tbl [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
            alu = tbl[f3];
            if (f3 == 0 && op == 7'h33 && f7) alu = 1;
            if (f3 == 5 && f7) alu = 9;
        end else if (op == 7'h63) begin
            alu = (f3 < 2) ? 1 : (f3 < 6) ? 5 : 6;
        end
        return {rw, mw, br, jp, jr, aa, ab, 2'(res), 3'(imm), 4'(alu)};
    endfunction

    function automatic logic [15:0] obs_ctrl();
        return {bus.reg_write_e, bus.mem_write_e, bus.branch_e, bus.jump_e, bus.jalr_e,
                bus.alu_src_a_e, bus.alu_src_b_e, bus.result_src_e, bus.imm_src_e, bus.alu_ctrl_e};
    endfunction

    task automatic check_state();
        check("out_valid", bus.out_valid, q.size() != 0);
        check("in_ready", bus.in_ready, q.size() < 2);
        check("illegal_cnt", bus.illegal_cnt, cnt_m);
        if (q.size() != 0) begin
            check("head_instr", bus.instr_e, q[0].instr);
            check("head_pc", bus.pc_e, q[0].pc);
            check("head_ctrl", obs_ctrl(), exp_ctrl(q[0].instr));
            check("head_illegal", bus.illegal_e, TRAP && !known_op(q[0].instr[6:0]));
            if (q[0].instr[6:0] == 7'h63)
                check("head_br_funct3", bus.br_funct3_e, q[0].instr[14:12]);
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bit acc, pop;
        bus.in_valid  = v;
        bus.instr_d   = ins;
        bus.pc_d      = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        acc = v && (q.size() < 2);
        pop = ordy && (q.size() != 0);
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back('{instr: ins, pc: pc});
                if (TRAP && !known_op(ins[6:0]) && cnt_m < (1 << CNTW) - 1) cnt_m++;
            end
        end
        check_state();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic [6:0] bad [4] = '{7'h7F, 7'h00, 7'h0F, 7'h73};
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        r[6:0] = (k == 9) ? bad[$urandom_range(0, 3)] : ops[k];
        if (r[6:0] == 7'h63 && r[14:13] == 2'b01) r[14:12] = 3'b000;
        return r;
    endfunction

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr_d = '0; bus.pc_d = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_ctrl", obs_ctrl(), 16'h0);
        check("rst_instr_pc", {bus.instr_e, bus.pc_e}, 64'h0);
        check("rst_misc", {bus.br_funct3_e, bus.illegal_e}, 4'h0);
        check("rst_illegal_cnt", bus.illegal_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // add, sub, srai, addi with high immediate bits
        cycle(1, 32'h003100B3, 32'h100, 1, 0);
        check("add_fields", {bus.out_valid, bus.reg_write_e, bus.alu_ctrl_e, bus.result_src_e, bus.alu_src_b_e}, {2'b11, 4'd0, 2'b00, 1'b0});
        cycle(1, 32'h403100B3, 32'h104, 1, 0);
        check("sub_alu", bus.alu_ctrl_e, 4'd1);
        cycle(1, 32'h4031D093, 32'h108, 1, 0);
        check("srai_alu", {bus.alu_ctrl_e, bus.alu_src_b_e}, {4'd9, 1'b1});
        cycle(1, 32'hFE010093, 32'h10C, 1, 0);
        check("addi_alu", bus.alu_ctrl_e, 4'd0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // back-pressure: third push held until space frees up
        cycle(1, 32'h00208033, 32'h200, 0, 0);
        cycle(1, 32'h0020C033, 32'h204, 0, 0);
        check("bp_full", bus.in_ready, 1'b0);
        cycle(1, 32'h0020E033, 32'h208, 0, 0);
        cycle(1, 32'h0020E033, 32'h208, 1, 0);
        cycle(1, 32'h0020E033, 32'h208, 1, 0);
        check("bp_third", bus.instr_e, 32'h0020E033);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // lui / auipc / jalr / bltu
        cycle(1, 32'h000010B7, 32'h300, 1, 0);
        check("lui", {bus.result_src_e, bus.imm_src_e}, {2'b11, 3'b100});
        cycle(1, 32'h00001097, 32'h304, 1, 0);
        check("auipc", {bus.alu_src_a_e, bus.alu_src_b_e}, 2'b11);
        cycle(1, 32'h000080E7, 32'h308, 1, 0);
        check("jalr", {bus.jalr_e, bus.jump_e, bus.result_src_e}, {2'b11, 2'b10});
        cycle(1, 32'h0020E063, 32'h30C, 1, 0);
        check("bltu", {bus.branch_e, bus.alu_ctrl_e, bus.br_funct3_e}, {1'b1, 4'd6, 3'b110});
        cycle(0, 32'h0, 32'h0, 1, 0);

        // flush at count 2 with a push attempt
        cycle(1, 32'h00000013, 32'h400, 0, 0);
        cycle(1, 32'h00100013, 32'h404, 0, 0);
        cycle(1, 32'h00200013, 32'h408, 0, 1);
        check("flush_empty", bus.out_valid, 1'b0);
        cycle(1, 32'h0000007F, 32'h40C, 0, 1);
        cycle(0, 32'h0, 32'h0, 1, 0);
        check("flush_no_ghost", bus.out_valid, 1'b0);

        // illegal opcode three times
        repeat (3) begin
            cycle(1, 32'h0000007F, 32'h500, 1, 0);
            check("illegal_head", {bus.illegal_e, bus.reg_write_e, bus.mem_write_e}, {TRAP, 2'b00});
        end
        check("illegal_cnt3", bus.illegal_cnt, TRAP ? 3 : 0);

        // async reset mid-stream
        cycle(1, 32'h003100B3, 32'h600, 0, 0);
        cycle(1, 32'h0000007F, 32'h604, 0, 0);
        #3;
        rst = 1'b1;
        #2;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_cnt", bus.illegal_cnt, 0);
        q.delete();
        cnt_m = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
